imem_loader: RTL

Boot-time writer for the CPU instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction ROM's write port at a word index, the same index the CPU PC uses on the read side. The CPU is held in reset until a frame passes its checksum.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/loader_timeout.sv | 30 +++
 rtl/imem_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_pkg;

    localparam logic [7:0] START_BYTE     = 8'hA5;
    localparam int         DEFAULT_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Words in a frame: a count of 0 means a full image, and counts larger
    // than the memory are clipped to its size.
    function automatic int clip_count(input logic [7:0] n, input int aw);
        int full;
        full = 1 << aw;
        if (n == 8'd0 || int'(n) > full) begin
            return full;
        end
        return int'(n);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; expired is high while the count sits at TIMEOUT_CYC.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_reg;

    // Count idle cycles while enabled, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expired = en && (cnt_reg == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes little-endian words into
// the instruction memory and releases the CPU once the checksum matches.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // One extra bit so a full image (2^ADDR_W words) is representable.
    localparam int WL_W = ADDR_W + 1;

    state_t            state_reg;
    logic [ADDR_W-1:0] word_idx_reg;
    logic [WL_W-1:0]   words_left_reg;
    logic [1:0]        byte_idx_reg;
    logic [23:0]       word_reg;       // first three bytes of the current word
    logic [7:0]        cksum_reg;

    logic accept;
    logic tmo_en;
    logic expired;

    assign accept = in_valid && in_ready;
    assign tmo_en = (state_reg == COUNT) || (state_reg == DATA) || (state_reg == CHECK);

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (tmo_en),
        .expired (expired)
    );

    // Frame FSM with word assembly, checksum and registered memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            word_idx_reg   <= '0;
            words_left_reg <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            cksum_reg      <= '0;
            in_ready       <= 1'b1;
            mem_we         <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= 1'b1;
            if (expired) begin
                // Timeout has priority; a byte arriving now is dropped.
                state_reg <= ERROR;
                err       <= 1'b1;
            end else if (accept) begin
                case (state_reg)
                    IDLE, DONE, ERROR: begin
                        if (in_data == START_BYTE) begin
                            state_reg    <= COUNT;
                            word_idx_reg <= '0;
                            byte_idx_reg <= '0;
                            cksum_reg    <= '0;
                            done         <= 1'b0;
                            err          <= 1'b0;
                            cpu_hold     <= 1'b1;
                        end
                    end
                    COUNT: begin
                        words_left_reg <= WL_W'(clip_count(in_data, ADDR_W));
                        state_reg      <= DATA;
                    end
                    DATA: begin
                        cksum_reg    <= cksum_reg ^ in_data;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            mem_we         <= 1'b1;
                            in_ready       <= 1'b0;
                            mem_waddr      <= word_idx_reg;
                            mem_wdata      <= {in_data, word_reg};
                            word_idx_reg   <= word_idx_reg + ADDR_W'(1);
                            words_left_reg <= words_left_reg - WL_W'(1);
                            if (words_left_reg == WL_W'(1)) begin
                                state_reg <= CHECK;
                            end
                        end else begin
                            word_reg <= {in_data, word_reg[23:8]};
                        end
                    end
                    CHECK: begin
                        if (in_data == cksum_reg) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state_reg <= ERROR;
                            err       <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
